// File: rtl/stream_argmax.sv
// Windowed streaming argmax: finds the max, the index of its first occurrence, and
// whether it repeated, over each window of N unsigned elements. valid/ready on both sides.
module stream_argmax #(
   parameter int DW = 4,
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_max,
   output logic [IW-1:0] out_idx,
   output logic          out_tie
);

   // state | meaning
   // ACC   | accepting window elements, updating running max/idx/tie
   // HOLD  | window result presented, waiting for the consumer
   typedef enum logic {ACC, HOLD} state_e;

   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_e        state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] run_max_q, run_max_d;
   logic [IW-1:0] run_idx_q, run_idx_d;
   logic          run_tie_q, run_tie_d;
   logic [DW-1:0] out_max_q, out_max_d;
   logic [IW-1:0] out_idx_q, out_idx_d;
   logic          out_tie_q, out_tie_d;

   logic [DW-1:0] elem_max;
   logic [IW-1:0] elem_idx;
   logic          elem_tie;
   logic          elem_fire;

   assign out_valid = (state_q == HOLD);
   assign in_ready  = !out_valid;
   assign out_max   = out_max_q;
   assign out_idx   = out_idx_q;
   assign out_tie   = out_tie_q;
   assign elem_fire = in_valid && (state_q == ACC);

   // Running state after folding in the current element; element 0 always seeds.
   always_comb begin
      elem_max = run_max_q;
      elem_idx = run_idx_q;
      elem_tie = run_tie_q;
      if (cnt_q == '0) begin
         elem_max = in_data;
         elem_idx = '0;
         elem_tie = 1'b0;
      end else if (in_data > run_max_q) begin
         elem_max = in_data;
         elem_idx = cnt_q;
         elem_tie = 1'b0;
      end else if (in_data == run_max_q) begin
         elem_tie = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      run_max_d = run_max_q;
      run_idx_d = run_idx_q;
      run_tie_d = run_tie_q;
      out_max_d = out_max_q;
      out_idx_d = out_idx_q;
      out_tie_d = out_tie_q;
      unique case (state_q)
         ACC: begin
            if (elem_fire) begin
               run_max_d = elem_max;
               run_idx_d = elem_idx;
               run_tie_d = elem_tie;
               if (cnt_q == LAST) begin
                  out_max_d = elem_max;
                  out_idx_d = elem_idx;
                  out_tie_d = elem_tie;
                  cnt_d     = '0;
                  state_d   = HOLD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (out_ready) state_d = ACC;
         end
         default: state_d = ACC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ACC;
         cnt_q     <= '0;
         run_max_q <= '0;
         run_idx_q <= '0;
         run_tie_q <= 1'b0;
         out_max_q <= '0;
         out_idx_q <= '0;
         out_tie_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         run_max_q <= run_max_d;
         run_idx_q <= run_idx_d;
         run_tie_q <= run_tie_d;
         out_max_q <= out_max_d;
         out_idx_q <= out_idx_d;
         out_tie_q <= out_tie_d;
      end
   end

endmodule

// File: tb/tb_stream_argmax.sv
// Directed table-driven bench for stream_argmax (DW=4, N=8, IW=3).
module tb_stream_argmax;

   localparam int DW = 4;
   localparam int N  = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_max;
   logic [IW-1:0] out_idx;
   logic          out_tie;

   int errors = 0;
   int checks = 0;

   stream_argmax #(.DW(DW), .N(N), .IW(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_max   (out_max),
      .out_idx   (out_idx),
      .out_tie   (out_tie)
   );

   always #5 clk = ~clk;

   // Nibble i of v is element i of the window.
   typedef struct {
      logic [31:0] v;
      logic [3:0]  mx;
      logic [2:0]  ix;
      logic        tie;
      int          duty;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Present one element until it is accepted; duty < 100 inserts random idle cycles.
   task automatic push(input logic [DW-1:0] d, input int duty);
      int guard;
      guard = 0;
      while (1) begin
         @(negedge clk);
         if (duty < 100 && $urandom_range(99) >= duty) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
         end else begin
            in_valid = 1'b1;
            in_data  = d;
            if (in_ready) begin
               @(posedge clk);
               return;
            end
         end
         guard++;
         if (guard > 200) begin
            chk("push_timeout", 1, 0);
            return;
         end
      end
   endtask

   task automatic push_window(input logic [31:0] v, input int duty);
      for (int i = 0; i < N; i++) push(v[i*4 +: 4], duty);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic chk_result(input string tag, input logic [3:0] mx, input logic [2:0] ix,
                             input logic t);
      chk({tag, "_valid"}, int'(out_valid), 1);
      chk({tag, "_max"}, int'(out_max), int'(mx));
      chk({tag, "_idx"}, int'(out_idx), int'(ix));
      chk({tag, "_tie"}, int'(out_tie), int'(t));
   endtask

   function automatic logic [7:0] ref_model(input logic [31:0] v);
      logic [3:0] mx;
      logic [2:0] ix;
      logic       t;
      logic [3:0] e;
      mx = v[3:0];
      ix = '0;
      t  = 1'b0;
      for (int i = 1; i < N; i++) begin
         e = v[i*4 +: 4];
         if (e > mx) begin
            mx = e;
            ix = 3'(i);
            t  = 1'b0;
         end else if (e == mx) begin
            t = 1'b1;
         end
      end
      return {mx, ix, t};
   endfunction

   logic [31:0] b2b_v[3];
   logic [7:0]  b2b_res[4];
   int          b2b_stamp[4];
   int          b2b_n;

   initial begin
      vecs[0] = '{32'h0491_9273, 4'd9,  3'd3, 1'b1, 100};
      vecs[1] = '{32'h7654_3210, 4'd7,  3'd7, 1'b0, 100};
      vecs[2] = '{32'h5555_5555, 4'd5,  3'd0, 1'b1, 100};
      vecs[3] = '{32'hFFFF_FFFF, 4'd15, 3'd0, 1'b1, 100};
      vecs[4] = '{32'h432F_0F11, 4'd15, 3'd2, 1'b1, 30};
      vecs[5] = '{32'h0000_0000, 4'd0,  3'd0, 1'b1, 100};
      vecs[6] = '{32'h9121_2121, 4'd9,  3'd7, 1'b0, 100};
      vecs[7] = '{32'h4321_0F3F, 4'd15, 3'd0, 1'b1, 100};
      vecs[8] = '{32'h6543_21EF, 4'd15, 3'd0, 1'b0, 100};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_ready", int'(in_ready), 1);
      chk("rst_max", int'(out_max), 0);
      chk("rst_idx", int'(out_idx), 0);
      chk("rst_tie", int'(out_tie), 0);
      rst = 1'b0;

      for (int k = 0; k < 9; k++) begin
         push_window(vecs[k].v, vecs[k].duty);
         chk_result($sformatf("vec%0d", k), vecs[k].mx, vecs[k].ix, vecs[k].tie);
         @(negedge clk);
         chk($sformatf("vec%0d_drop", k), int'(out_valid), 0);
         chk($sformatf("vec%0d_ready", k), int'(in_ready), 1);
      end

      // Backpressure: result held, offered 14s must not be taken.
      out_ready = 1'b0;
      push_window(vecs[0].v, 100);
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_data  = 4'd14;
         chk_result("stall", 4'd9, 3'd3, 1'b1);
         chk("stall_ready", int'(in_ready), 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      push(4'd14, 100);
      for (int i = 1; i < N; i++) push(4'd0, 100);
      @(negedge clk);
      in_valid = 1'b0;
      chk_result("after_stall", 4'd14, 3'd0, 1'b0);
      @(negedge clk);

      // Async reset mid-window.
      for (int i = 0; i < 5; i++) push(4'd15, 100);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_valid", int'(out_valid), 0);
      chk("rst_mid_ready", int'(in_ready), 1);
      @(negedge clk);
      #2 rst = 1'b0;
      push_window(32'h0000_0008, 100);
      chk_result("post_rst", 4'd8, 3'd0, 1'b0);
      @(negedge clk);

      // Async reset while a result is pending.
      out_ready = 1'b0;
      push_window(32'h7654_3210, 100);
      chk("hold_pre_rst", int'(out_valid), 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_hold_valid", int'(out_valid), 0);
      chk("rst_hold_ready", int'(in_ready), 1);
      chk("rst_hold_max", int'(out_max), 0);
      @(negedge clk);
      #2 rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);

      // Back-to-back windows with a concurrent result monitor.
      b2b_v[0] = 32'h1A2B_3C4D;
      b2b_v[1] = 32'h0707_0707;
      b2b_v[2] = 32'hE123_4567;
      b2b_n    = 0;
      fork
         begin
            for (int w = 0; w < 3; w++)
               for (int i = 0; i < N; i++) push(b2b_v[w][i*4 +: 4], 100);
            @(negedge clk);
            in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 45; c++) begin
               @(negedge clk);
               if (out_valid) begin
                  if (b2b_n < 4) begin
                     b2b_res[b2b_n]   = {out_max, out_idx, out_tie};
                     b2b_stamp[b2b_n] = c;
                  end
                  b2b_n++;
               end
            end
         end
      join
      chk("b2b_count", b2b_n, 3);
      for (int w = 0; w < 3; w++) begin
         if (w < b2b_n) chk($sformatf("b2b_res%0d", w), int'(b2b_res[w]), int'(ref_model(b2b_v[w])));
         else chk($sformatf("b2b_missing%0d", w), 0, 1);
      end
      for (int w = 1; w < 3; w++)
         if (w < b2b_n)
            chk($sformatf("b2b_gap%0d", w), b2b_stamp[w] - b2b_stamp[w-1], N + 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_argmax.md
Name: stream_argmax

Overview:
- Downstream consumer of the 4-bit magnitude comparison used in the Res-DNN datapath.
- Accepts a stream of unsigned activation values in fixed windows of N elements.
- Per window, finds the maximum value, the index of its first occurrence, and whether the maximum occurred more than once.
- Feeds max-pooling and final-layer class selection; uses a valid/ready handshake on both sides.

Parameters:
- DW, 4, data width of each element (unsigned).
- N, 8, elements per window; legal range 2..256.
- IW, 3, index width; must satisfy 2^IW >= N.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a valid element.
- in_ready  output  1  block can accept an element this cycle.
- in_data  input  DW  unsigned element.
- out_valid  output  1  window result is available.
- out_ready  input  1  consumer accepts the result.
- out_max  output  DW  largest element of the window.
- out_idx  output  IW  position (0..N-1) of the first occurrence of out_max.
- out_tie  output  1  out_max occurred at two or more positions.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is asynchronous and active-high; its assertion takes effect immediately, without waiting for a clock edge.
  - While rst is high: state=ACC, element counter=0, out_valid=0, out_max=0, out_idx=0, out_tie=0, internal running max/idx/tie=0.
  - in_ready=1 after reset.
- Handshakes:
  - An element transfer occurs on a rising edge where in_valid && in_ready.
  - A result transfer occurs on a rising edge where out_valid && out_ready.
- States:
  - ACC: in_ready=1, out_valid=0. Each transfer is processed by the element rules below; cnt then increments. On the transfer with cnt==N-1, latch the final max/idx/tie into the outputs, clear cnt, go to HOLD.
  - HOLD: in_ready=0, out_valid=1. Outputs hold stable until the result transfer. On that edge go to ACC; out_valid=0 next cycle.
- Element rules:
  - At cnt==0 the element unconditionally seeds the state: max=in_data, idx=0, tie=0.
  - At cnt>0 the comparison is unsigned:
    - in_data > max: max=in_data, idx=cnt, tie=0.
    - in_data == max: max and idx unchanged, tie=1.
    - in_data < max: no change.
  - On the final (cnt==N-1) element, the rule is applied before latching. The output therefore reflects all N elements.
- Latency and throughput:
  - out_valid rises on the edge of the N-th element transfer and is visible the following cycle.
  - in_ready is combinational from state only (in_ready = !out_valid), never from in_valid or out_ready.
  - Best-case throughput is one window per N+1 cycles.
- Boundary conditions:
  - in_valid low in ACC: hold all state; gaps between elements are allowed.
  - out_ready high while in ACC: ignored.
  - out_ready low in HOLD: stall indefinitely; outputs and in_ready=0 held; in_data ignored.
  - All-equal window: out_idx=0, out_tie=1.
  - Max at the last position: out_idx=N-1, out_tie=0.
  - Value DW'h0 throughout: out_max=0, out_idx=0, out_tie=1.
  - Max value (all ones) appears first: later equal values set tie; later smaller values cause no change.
  - cnt never exceeds N-1; it wraps to 0 only on the window-final transfer.
  - Reset mid-window or in HOLD: the partial window or pending result is discarded, with no output produced. The next accepted element is index 0 of a fresh window.
- Outputs are registered; no combinational path from in_data to out_*.

Test Plan:
- Basic window, N=8, values 3,7,2,9,1,9,4,0, out_ready=1 -> one cycle after the 8th transfer: out_valid=1, out_max=9, out_idx=3, out_tie=1. Next cycle out_valid=0, in_ready=1.
- Strictly increasing 0..7 -> out_max=7, out_idx=7, out_tie=0. All-equal 5s -> out_max=5, out_idx=0, out_tie=1. All 15 -> out_max=15, out_idx=0, out_tie=1.
- Backpressure: hold out_ready=0 for 10 cycles after the result while driving in_valid=1 with 14 -> in_ready=0 throughout, outputs stable, 14 not consumed. Release -> the next window starts with the 14 as index 0.
- Input gaps: random in_valid duty of 30% over window 1,1,15,0,15,2,3,4 -> out_max=15, out_idx=2, out_tie=1, same as the gap-free run.
- Async reset: assert rst between clock edges after 5 elements -> out_valid=0 and in_ready=1 immediately. A following full window 8,0,0,0,0,0,0,0 -> out_max=8, out_idx=0, out_tie=0, with no trace of the aborted data.
- Back-to-back: three windows with out_ready tied high -> results every N+1=9 cycles, each matching a reference model, no dropped or duplicated result.
